// File: rtl/spi_master_shift_engine.sv
// SPI master shift engine: single chip select, fixed word length, MSB first.
// Each rising edge of the synchronised div_clock is one SCLK half-period tick.
module spi_master_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  in_clock,
    input  logic                  reset,
    input  logic                  div_clock,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);
    localparam int CW = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_EDGE = CW'(2 * DATA_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic                  sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]         edge_cnt_q, edge_cnt_d, edge_cnt_nxt;
    logic                  sample_q, sample_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic                  tx_ready_q, tx_ready_d, busy_q, busy_d, rx_valid_q, rx_valid_d;
    logic                  tick;

    assign tick         = sync2_q & ~hist_q;
    assign edge_cnt_nxt = edge_cnt_q + 1'b1;

    always_comb begin
        sync1_d    = div_clock;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        state_d    = state_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        edge_cnt_d = edge_cnt_q;
        sample_d   = sample_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d    = tx_data;
                    edge_cnt_d = '0;
                    state_d    = ST_SETUP;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    mosi_d     = CPHA ? 1'b0 : tx_data[DATA_WIDTH-1];
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_nxt;
                    if (edge_cnt_nxt[0]) begin
                        // Leading edge: CPHA=0 captures miso, CPHA=1 launches the next bit.
                        if (!CPHA) sample_d = miso;
                        else       mosi_d   = shift_q[DATA_WIDTH-1];
                    end else if (!CPHA) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], sample_q};
                        if (edge_cnt_nxt != LAST_EDGE) mosi_d = shift_q[DATA_WIDTH-2];
                    end else begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], miso};
                    end
                    if (edge_cnt_nxt == LAST_EDGE) begin
                        sclk_d  = CPOL;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= '0;
            sample_q   <= 1'b0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            edge_cnt_q <= edge_cnt_d;
            sample_q   <= sample_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master_shift_engine.sv
// Bench for the SPI shift engine: a mode-0 and a mode-3 instance share the request
// inputs and div_clock; each talks to a behavioural SPI slave kept here.
module tb_spi_master_shift_engine;
    localparam int W = 8;

    logic         in_clock = 1'b0;
    logic         reset = 1'b0;
    logic         div_clock = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;

    logic         tx_ready0, rx_valid0, busy0, sclk0, mosi0, miso0, cs_n0;
    logic         tx_ready1, rx_valid1, busy1, sclk1, mosi1, miso1, cs_n1;
    logic [W-1:0] rx_data0, rx_data1;

    int checks = 0;
    int errors = 0;

    bit          div_run = 1'b1;
    int unsigned half = 3;

    // Slave models: s_word is what the slave returns, got is what it received.
    logic [W-1:0] s_word0 = '0, s_word1 = '0, got0 = '0, got1 = '0;
    logic         m0_s = 1'b0, m1 = 1'b0, loop0 = 1'b0;
    int           idx0 = 0, idx1 = 0;
    int           rise0 = 0, fall0 = 0, rise1 = 0, fall1 = 0;
    int           sclk_any = 0, rxv0 = 0, div_rises = 0;

    assign miso0 = loop0 ? mosi0 : m0_s;
    assign miso1 = m1;

    spi_master_shift_engine #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .in_clock(in_clock), .reset(reset), .div_clock(div_clock),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
        .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
    );

    spi_master_shift_engine #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
        .in_clock(in_clock), .reset(reset), .div_clock(div_clock),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
    );

    always #5 in_clock = ~in_clock;

    // div_clock changes 2 ns after a falling in_clock edge; when stalled it is held high.
    always begin
        if (div_run) begin
            repeat (half) @(negedge in_clock);
            #2 div_clock = ~div_clock;
        end else begin
            div_clock = 1'b1;
            @(negedge in_clock);
        end
    end

    always @(posedge div_clock) div_rises++;
    always @(negedge in_clock) if (rx_valid0) rxv0++;
    always @(sclk0 or sclk1) sclk_any++;
    always @(posedge sclk0) if (!reset) rise0++;
    always @(negedge sclk0) if (!reset) fall0++;
    always @(posedge sclk1) if (!reset) rise1++;
    always @(negedge sclk1) if (!reset) fall1++;

    // Mode 0 slave: first bit valid at CS fall, sample on rising, change on falling.
    always @(negedge cs_n0) if (!reset) begin idx0 = 0; got0 = '0; m0_s = s_word0[W-1]; end
    always @(posedge sclk0) if (!reset && !cs_n0) got0 = {got0[W-2:0], mosi0};
    always @(negedge sclk0) if (!reset && !cs_n0) begin
        idx0++;
        if (idx0 < W) m0_s = s_word0[W-1-idx0];
    end

    // Mode 3 slave: change on falling (leading), sample on rising (trailing).
    always @(negedge cs_n1) if (!reset) begin idx1 = 0; got1 = '0; m1 = 1'b0; end
    always @(negedge sclk1) if (!reset && !cs_n1) begin
        if (idx1 < W) m1 = s_word1[W-1-idx1];
        idx1++;
    end
    always @(posedge sclk1) if (!reset && !cs_n1) got1 = {got1[W-2:0], mosi1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        rise0 = 0; fall0 = 0; rise1 = 0; fall1 = 0; div_rises = 0;
    endtask

    task automatic start_xfer(input logic [W-1:0] d);
        @(negedge in_clock);
        chk("tx_ready_idle", {tx_ready0, tx_ready1}, 2'b11);
        tx_data  = d;
        tx_valid = 1'b1;
        clear_counts();
        @(negedge in_clock);
        tx_valid = 1'b0;
        chk("busy_after_accept", {busy0, busy1, tx_ready0}, 3'b110);
        chk("cs_low_after_accept", {cs_n0, cs_n1}, 2'b00);
        chk("mosi_first", {mosi0, mosi1}, {d[W-1], 1'b0});
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge in_clock);
            if (rx_valid0) begin ok = 1'b1; break; end
        end
        chk("done_timeout", {31'd0, ok}, 1);
    endtask

    task automatic check_done(input logic [W-1:0] d, input logic [W-1:0] exp_rx0,
                              input logic [W-1:0] exp_rx1);
        chk("rx_valid_both", {rx_valid0, rx_valid1}, 2'b11);
        chk("rx_data0", rx_data0, exp_rx0);
        chk("rx_data1", rx_data1, exp_rx1);
        chk("slave0_got_mosi", got0, d);
        chk("slave1_got_mosi", got1, d);
        chk("idle_flags", {cs_n0, cs_n1, tx_ready0, busy0, tx_ready1, busy1}, 6'b111010);
        chk("sclk_idle", {sclk0, sclk1}, 2'b01);
        chk("mosi_idle", {mosi0, mosi1}, 2'b00);
        chk("edges0", rise0 * 100 + fall0, W * 100 + W);
        chk("edges1", rise1 * 100 + fall1, W * 100 + W);
        chk("tick_count_window", {31'd0, (div_rises >= 2*W+1 && div_rises <= 2*W+3)}, 1);
        @(negedge in_clock);
        chk("rx_valid_one_cycle", {rx_valid0, rx_valid1}, 2'b00);
    endtask

    task automatic full_xfer(input logic [W-1:0] d, input logic [W-1:0] s0,
                             input logic [W-1:0] s1, input logic lp);
        s_word0 = s0; s_word1 = s1; loop0 = lp;
        start_xfer(d);
        wait_done();
        check_done(d, lp ? d : s0, s1);
    endtask

    initial begin
        logic [W-1:0] d, d2, s0, s1;
        int snap, rxv_snap;
        bit ok;

        // Reset held with div_clock running: everything at reset values, SCLK silent.
        #2 reset = 1'b1;
        #1 sclk_any = 0;
        repeat (20) @(negedge in_clock);
        chk("rst_flags0", {tx_ready0, busy0, rx_valid0, cs_n0, sclk0, mosi0}, 6'b100100);
        chk("rst_flags1", {tx_ready1, busy1, rx_valid1, cs_n1, sclk1, mosi1}, 6'b100110);
        chk("rst_rx_data", {rx_data0, rx_data1}, 16'h0);
        chk("rst_no_sclk", sclk_any, 0);
        reset = 1'b0;
        repeat (5) @(negedge in_clock);

        // Mode 0 loopback of A5, mode 3 slave returns C3 while receiving A5.
        full_xfer(8'hA5, 8'h00, 8'hC3, 1'b1);
        // Mode 3 spec word 3C against slave C3.
        full_xfer(8'h3C, 8'h5A, 8'hC3, 1'b0);

        // Randomised words, slave replies, loopback choice and tick rate.
        for (int n = 0; n < 6; n++) begin
            half = $urandom_range(2, 5);
            d  = W'($urandom);
            s0 = W'($urandom);
            s1 = W'($urandom);
            full_xfer(d, s0, s1, 1'($urandom_range(0, 1)));
        end
        half = 3;

        // tx_valid held high with tx_data churning: only the first word goes out,
        // the second is accepted the cycle after rx_valid.
        d = W'($urandom); d2 = W'($urandom);
        s_word0 = 8'h96; s_word1 = 8'h69; loop0 = 1'b0;
        rxv_snap = rxv0;
        @(negedge in_clock);
        tx_data = d; tx_valid = 1'b1;
        clear_counts();
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge in_clock);
            if (rx_valid0) begin ok = 1'b1; break; end
            tx_data = W'($urandom);
        end
        chk("held_valid_timeout", {31'd0, ok}, 1);
        tx_data = d2;
        check_done(d, 8'h96, 8'h69);
        chk("second_accept", {busy0, busy1, cs_n0}, 3'b110);
        clear_counts();
        tx_valid = 1'b0;
        wait_done();
        check_done(d2, 8'h96, 8'h69);
        chk("two_rx_valid", rxv0 - rxv_snap, 2);

        // Reset after the third leading edge aborts the word without rx_valid.
        s_word0 = 8'h33; s_word1 = 8'hCC; loop0 = 1'b0;
        start_xfer(W'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge in_clock);
            if (rise0 >= 3) begin ok = 1'b1; break; end
        end
        chk("third_edge_timeout", {31'd0, ok}, 1);
        rxv_snap = rxv0;
        #3 reset = 1'b1;
        #1;
        chk("abort_cs_sclk", {cs_n0, cs_n1, sclk0, sclk1}, 4'b1101);
        chk("abort_flags", {tx_ready0, busy0, mosi0, rx_valid0}, 4'b1000);
        chk("abort_rx_data", {rx_data0, rx_data1}, 16'h0);
        repeat (3) @(negedge in_clock);
        reset = 1'b0;
        repeat (60) @(negedge in_clock);
        chk("abort_no_rx_valid", rxv0 - rxv_snap, 0);
        full_xfer(8'h81, 8'h7E, 8'hE7, 1'b0);

        // div_clock held high mid-transfer freezes everything; then it completes.
        d = W'($urandom); s0 = W'($urandom); s1 = W'($urandom);
        s_word0 = s0; s_word1 = s1; loop0 = 1'b0;
        start_xfer(d);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge in_clock);
            if (rise0 >= 4) begin ok = 1'b1; break; end
        end
        chk("stall_edge_timeout", {31'd0, ok}, 1);
        div_run = 1'b0;
        repeat (20) @(negedge in_clock);
        snap = rise0 + fall0;
        repeat (100) @(negedge in_clock);
        chk("stall_edges_frozen", rise0 + fall0, snap);
        chk("stall_sclk_level", {31'd0, sclk0}, snap % 2);
        chk("stall_cs_busy", {cs_n0, busy0, cs_n1, busy1}, 4'b0101);
        div_run = 1'b1;
        wait_done();
        check_done(d, s0, s1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
